pwm_dac_tx: RTL
===============

Name: pwm_dac_tx

Overview:
PWM DAC transmitter; the output-direction counterpart of the delta-ADC core. Accepts W-bit duty samples through a valid-strobe/ready interface and double-buffers them. Emits a PWM waveform whose period comes from Period_counter_val, for an external RC filter. Samples are applied only at period boundaries, so each PWM period is glitch-free. A stretched period-end strobe paces the upstream sample source.

Parameters:
W, 16, width of period, duty and counters
STROBE_CYCLES, 16, cycles Period_end_strb stays high after each boundary (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Period_counter_val  input  W  PWM period in clk cycles; 0 = disabled
Sample_val  input  W  duty sample (high cycles per period)
Sample_valid_strb  input  1  one-cycle pulse qualifying Sample_val
Sample_ready  output  1  high when pending buffer is empty
PWM_O  output  1  registered PWM output
Period_end_strb  output  1  stretched strobe after each period boundary
Overrun_flag  output  1  sticky: a sample was dropped
Underrun_flag  output  1  sticky: a boundary occurred with no new sample

Behaviour:
- Reset (synchronous, priority over all else):
  - cnt=0, P_lat=0, duty_act=0, pending empty, started=0.
  - PWM_O=0, Sample_ready=1, Period_end_strb=0, both flags 0, strobe counter 0.
  - Reset mid-period discards the active and pending samples.
- Disabled state (P_lat==0):
  - Each cycle, P_lat <= Period_counter_val and cnt held at 0.
  - PWM_O=0; no boundaries, strobes or underruns.
  - Sample handshake still works; the pending sample is retained.
- Running (P_lat>0):
  - cnt counts 0..P_lat-1.
  - Boundary = cycle where cnt==P_lat-1. Next cycle: cnt=0 and P_lat <= Period_counter_val.
  - A mid-period change of Period_counter_val takes effect only at the next period.
- PWM_O is registered: PWM_O(t+1) = (cnt(t) < duty_act(t)).
  - duty_act=0 gives constant low.
  - duty_act >= P_lat gives constant high.
  - Comparison is unsigned, W bits.
- Input handshake:
  - Sample accepted on a cycle with Sample_valid_strb=1.
  - If pending is empty, the sample enters pending and Sample_ready drops the next cycle.
  - If pending is full and it is not a boundary cycle, the sample is dropped, Overrun_flag is set, and pending is unchanged.
- At a boundary:
  - Pending full: duty_act <= pending; pending cleared (Sample_ready=1 next cycle).
  - Pending empty, no strobe: duty_act retained; Underrun_flag is set if started=1.
  - Pending empty with a simultaneous strobe: Sample_val goes directly to duty_act; pending stays empty; no underrun.
  - Pending full with a simultaneous strobe: pending moves to duty_act and Sample_val enters pending; no overrun.
- started is set on the first accepted sample, which suppresses underrun at startup.
- Period_end_strb:
  - Strobe counter loads STROBE_CYCLES at each boundary.
  - Period_end_strb = (counter != 0), registered, so it rises one cycle after the boundary.
  - Decrements each cycle.
  - If P_lat < STROBE_CYCLES, a boundary reloads the counter and the strobe stays high.
- Flags clear only on reset.

Test Plan:
- Stimulus: reset, Period=10, one strobe with Sample_val=3 while disabled. Response:
  - Disabled cycles: PWM_O=0.
  - After that sample is applied at a boundary: PWM_O high 3 cycles, low 7 cycles, repeating.
  - Period_end_strb rises 1 cycle after each cnt==9, high STROBE_CYCLES=4 cycles.
- Stimulus: Period=10, duty 0, then 10, then 0xFFFF, each loaded at a boundary. Response: PWM_O constant 0, then constant 1, then constant 1.
- Stimulus: Period=10, two strobes (2 then 7) within one period. Response:
  - Sample_ready=0 after the first strobe.
  - Overrun_flag=1; next period duty=2; 7 is never output.
- Stimulus: empty pending, strobe Sample_val=5 exactly on the cnt==9 cycle. Response: next period has exactly 5 high cycles; Underrun_flag stays 0.
- Stimulus: no new sample for two boundaries after duty=4. Response: duty 4 repeats; Underrun_flag=1 after the first such boundary.
- Stimulus 1: Period changed 10->6 at cnt=3. Response 1: current period completes 10 cycles; subsequent periods are 6 cycles.
- Stimulus 2: Period=0. Response 2: PWM_O=0 and no strobes.
- Stimulus 3: reset asserted mid-period. Response 3: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/pwm_dac_tx_if.sv
// Duty-sample handshake between an upstream sample source (master) and the PWM DAC (slave).
interface pwm_dac_tx_if #(parameter int W = 16);
  logic [W-1:0] Sample_val;
  logic         Sample_valid_strb;
  logic         Sample_ready;

  modport master (output Sample_val, output Sample_valid_strb, input Sample_ready);
  modport slave  (input Sample_val, input Sample_valid_strb, output Sample_ready);
endinterface

// File: rtl/pwm_dac_tx.sv
// PWM DAC transmitter: double-buffered duty samples, applied only at period boundaries,
// with a stretched period-end strobe for pacing the sample source.
module pwm_dac_tx #(
  parameter int W             = 16,
  parameter int STROBE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  Period_counter_val,
  pwm_dac_tx_if.slave   smp,
  output logic          PWM_O,
  output logic          Period_end_strb,
  output logic          Overrun_flag,
  output logic          Underrun_flag
);

  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam logic [W-1:0]  CNT_ZERO  = {W{1'b0}};
  localparam logic [W-1:0]  CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] STRB_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] STRB_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] STRB_LOAD = SW'(STROBE_CYCLES);

  logic [W-1:0]  cnt_r, p_lat_r, duty_act_r, pend_r;
  logic          pend_full_r, started_r, pwm_r, strb_r, ready_r, ovr_r, und_r;
  logic [SW-1:0] strb_cnt_r;

  logic          running_s, boundary_s, pwm_nxt_s;
  logic [W-1:0]  cnt_nxt_s, p_lat_nxt_s, duty_nxt_s, pend_nxt_s;
  logic          pend_full_nxt_s, ovr_set_s, und_set_s;
  logic [SW-1:0] strb_cnt_nxt_s;

  // Period counter, period latch, PWM compare and strobe stretch counter
  always_comb begin
    running_s      = (p_lat_r != CNT_ZERO);
    boundary_s     = running_s && (cnt_r == (p_lat_r - CNT_ONE));
    cnt_nxt_s      = CNT_ZERO;
    p_lat_nxt_s    = p_lat_r;
    strb_cnt_nxt_s = STRB_ZERO;
    if (!running_s || boundary_s) begin
      cnt_nxt_s   = CNT_ZERO;
      p_lat_nxt_s = Period_counter_val;
    end else begin
      cnt_nxt_s   = cnt_r + CNT_ONE;
      p_lat_nxt_s = p_lat_r;
    end
    if (boundary_s) begin
      strb_cnt_nxt_s = STRB_LOAD;
    end else if (strb_cnt_r != STRB_ZERO) begin
      strb_cnt_nxt_s = strb_cnt_r - STRB_ONE;
    end else begin
      strb_cnt_nxt_s = STRB_ZERO;
    end
    pwm_nxt_s = running_s && (cnt_r < duty_act_r);
  end

  // Double buffer: a strobe on a boundary bypasses or refills pending instead of overrunning
  always_comb begin
    duty_nxt_s      = duty_act_r;
    pend_nxt_s      = pend_r;
    pend_full_nxt_s = pend_full_r;
    ovr_set_s       = 1'b0;
    und_set_s       = 1'b0;
    if (boundary_s) begin
      if (pend_full_r) begin
        duty_nxt_s = pend_r;
        if (smp.Sample_valid_strb) begin
          pend_nxt_s      = smp.Sample_val;
          pend_full_nxt_s = 1'b1;
        end else begin
          pend_full_nxt_s = 1'b0;
        end
      end else if (smp.Sample_valid_strb) begin
        duty_nxt_s = smp.Sample_val;
      end else begin
        und_set_s = started_r;
      end
    end else if (smp.Sample_valid_strb) begin
      if (pend_full_r) begin
        ovr_set_s = 1'b1;
      end else begin
        pend_nxt_s      = smp.Sample_val;
        pend_full_nxt_s = 1'b1;
      end
    end else begin
      pend_full_nxt_s = pend_full_r;
    end
  end

  // State and registered outputs; reset discards active and pending samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= CNT_ZERO;
      p_lat_r     <= CNT_ZERO;
      duty_act_r  <= CNT_ZERO;
      pend_r      <= CNT_ZERO;
      pend_full_r <= 1'b0;
      started_r   <= 1'b0;
      pwm_r       <= 1'b0;
      strb_cnt_r  <= STRB_ZERO;
      strb_r      <= 1'b0;
      ready_r     <= 1'b1;
      ovr_r       <= 1'b0;
      und_r       <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      p_lat_r     <= p_lat_nxt_s;
      duty_act_r  <= duty_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_full_r <= pend_full_nxt_s;
      started_r   <= started_r | smp.Sample_valid_strb;
      pwm_r       <= pwm_nxt_s;
      strb_cnt_r  <= strb_cnt_nxt_s;
      strb_r      <= (strb_cnt_nxt_s != STRB_ZERO);
      ready_r     <= ~pend_full_nxt_s;
      ovr_r       <= ovr_r | ovr_set_s;
      und_r       <= und_r | und_set_s;
    end
  end

  assign PWM_O            = pwm_r;
  assign Period_end_strb  = strb_r;
  assign Overrun_flag     = ovr_r;
  assign Underrun_flag    = und_r;
  assign smp.Sample_ready = ready_r;

endmodule
